// File: rtl/writeback_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | writeback_arbiter: register-file write-port arbiter (ALU + buffered long-   |
// | latency results) with RAW pending scoreboard. Option macro: WB_BYPASS_EN.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module writeback_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alu_valid,
  input  logic [4:0]                  alu_reg,
  input  logic [31:0]                 alu_data,
  input  logic                        mem_valid,
  output logic                        mem_ready,
  input  logic [4:0]                  mem_reg,
  input  logic [31:0]                 mem_data,
  input  logic                        issue_valid,
  input  logic [4:0]                  issue_reg,
  input  logic [4:0]                  query_reg1,
  input  logic [4:0]                  query_reg2,
  output logic                        query_busy1,
  output logic                        query_busy2,
  output logic                        write_enable,
  output logic [4:0]                  write_reg,
  output logic [31:0]                 write_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [4:0]       fifo_reg_q  [FIFO_DEPTH];
  logic [31:0]      fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      pending_q, pending_d;
  logic             we_q, we_d;
  logic [4:0]       wreg_q, wreg_d;
  logic [31:0]      wdata_q, wdata_d;

  logic             w_xfer;
  logic             w_push;
  logic             w_pop;
  logic             w_bypass;
  logic [4:0]       w_head_reg;
  logic [31:0]      w_head_data;

  // Readiness looks only at the registered count, so a same-cycle pop never opens a slot early.
  assign mem_ready   = reset && (count_q < DEPTH_C);
  assign w_xfer      = mem_valid && mem_ready;
  assign w_head_reg  = fifo_reg_q[rd_ptr_q];
  assign w_head_data = fifo_data_q[rd_ptr_q];

`ifdef WB_BYPASS_EN
  assign w_bypass = w_xfer && !alu_valid && (count_q == '0) && (mem_reg != 5'd0);
`else
  assign w_bypass = 1'b0;
`endif

  // Results for r0 finish the handshake but are dropped rather than queued.
  assign w_push = w_xfer && (mem_reg != 5'd0) && !w_bypass;
  assign w_pop  = !alu_valid && (count_q != '0);

  always_comb begin
    we_d     = 1'b0;
    wreg_d   = wreg_q;
    wdata_d  = wdata_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (alu_valid) begin
      if (alu_reg != 5'd0) begin
        we_d    = 1'b1;
        wreg_d  = alu_reg;
        wdata_d = alu_data;
      end
    end else if (w_pop) begin
      we_d     = 1'b1;
      wreg_d   = w_head_reg;
      wdata_d  = w_head_data;
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else if (w_bypass) begin
      we_d    = 1'b1;
      wreg_d  = mem_reg;
      wdata_d = mem_data;
    end
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (w_push && !w_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // A new issue to the register being retired this cycle must stay pending.
  always_comb begin
    pending_d = pending_q;
    if (w_pop) begin
      pending_d[w_head_reg] = 1'b0;
    end else if (w_bypass) begin
      pending_d[mem_reg] = 1'b0;
    end
    if (issue_valid && (issue_reg != 5'd0)) begin
      pending_d[issue_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      we_q      <= 1'b0;
      wreg_q    <= 5'd0;
      wdata_q   <= 32'd0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= 32'd0;
    end else begin
      we_q      <= we_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  // Storage needs no reset: occupancy is governed entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_reg_q[wr_ptr_q]  <= mem_reg;
      fifo_data_q[wr_ptr_q] <= mem_data;
    end
  end

  assign write_enable = we_q;
  assign write_reg    = wreg_q;
  assign write_data   = wdata_q;
  assign fifo_count   = count_q;
  assign query_busy1  = (query_reg1 != 5'd0) && pending_q[query_reg1];
  assign query_busy2  = (query_reg2 != 5'd0) && pending_q[query_reg2];

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_writeback_arbiter: directed and random checks of writeback_arbiter       |
// | against a queue-based reference model. Honours WB_BYPASS_EN.                |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_writeback_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_reg;
  logic [31:0] mem_data;
  logic        issue_valid;
  logic [4:0]  issue_reg;
  logic [4:0]  query_reg1;
  logic [4:0]  query_reg2;
  logic        query_busy1;
  logic        query_busy2;
  logic        write_enable;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  writeback_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_reg      (alu_reg),
    .alu_data     (alu_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_reg      (mem_reg),
    .mem_data     (mem_data),
    .issue_valid  (issue_valid),
    .issue_reg    (issue_reg),
    .query_reg1   (query_reg1),
    .query_reg2   (query_reg2),
    .query_busy1  (query_busy1),
    .query_busy2  (query_busy2),
    .write_enable (write_enable),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .fifo_count   (fifo_count)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: a queue of buffered results, a pending flag per register,
  // and the expected contents of the write port.
  logic [36:0] m_q [$];
  bit          m_pend [32];
  logic        m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  bit          last_xfer;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    bit          ready;
    bit          xfer;
    bit          bypassed;
    logic [36:0] h;
    ready    = reset && (m_q.size() < DEPTH);
    xfer     = mem_valid && ready;
    bypassed = 1'b0;
    if (!reset) begin
      m_q.delete();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_we   = 1'b0;
      m_reg  = 5'd0;
      m_data = 32'd0;
    end else begin
      if (alu_valid) begin
        m_we = (alu_reg != 5'd0);
        if (alu_reg != 5'd0) begin
          m_reg  = alu_reg;
          m_data = alu_data;
        end
      end else if (m_q.size() > 0) begin
        h      = m_q.pop_front();
        m_we   = 1'b1;
        m_reg  = h[36:32];
        m_data = h[31:0];
        m_pend[h[36:32]] = 1'b0;
      end
`ifdef WB_BYPASS_EN
      else if (xfer && mem_reg != 5'd0) begin
        m_we     = 1'b1;
        m_reg    = mem_reg;
        m_data   = mem_data;
        bypassed = 1'b1;
        m_pend[mem_reg] = 1'b0;
      end
`endif
      else begin
        m_we = 1'b0;
      end
      if (xfer && mem_reg != 5'd0 && !bypassed) m_q.push_back({mem_reg, mem_data});
      if (issue_valid && issue_reg != 5'd0) m_pend[issue_reg] = 1'b1;
    end
    last_xfer = xfer;
    @(posedge clk);
    #1;
    check({tag, ".we"},    32'(write_enable), 32'(m_we));
    check({tag, ".reg"},   32'(write_reg),    32'(m_reg));
    check({tag, ".data"},  write_data,        m_data);
    check({tag, ".count"}, 32'(fifo_count),   32'(m_q.size()));
    check({tag, ".ready"}, 32'(mem_ready),    32'(reset && (m_q.size() < DEPTH)));
    check({tag, ".busy1"}, 32'(query_busy1),  32'(query_reg1 != 5'd0 && m_pend[query_reg1]));
    check({tag, ".busy2"}, 32'(query_busy2),  32'(query_reg2 != 5'd0 && m_pend[query_reg2]));
  endtask

  task automatic idle_inputs();
    alu_valid   = 1'b0;
    mem_valid   = 1'b0;
    issue_valid = 1'b0;
  endtask

  initial begin
    // Reset with every input active.
    reset = 1'b0; alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'hA5A5A5A5;
    mem_valid = 1'b1; mem_reg = 5'd4; mem_data = 32'h11111111;
    issue_valid = 1'b1; issue_reg = 5'd6; query_reg1 = 5'd6; query_reg2 = 5'd4;
    tick("rst0");
    tick("rst1");
    check("rst_we", 32'(write_enable), 32'd0);
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_busy1", 32'(query_busy1), 32'd0);
    idle_inputs();
    reset = 1'b1;
    #1;
    check("rel_ready", 32'(mem_ready), 32'd1);

    // ALU path.
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
    tick("alu");
    check("alu_we", 32'(write_enable), 32'd1);
    check("alu_reg", 32'(write_reg), 32'd5);
    check("alu_data", write_data, 32'hDEADBEEF);
    alu_valid = 1'b0;
    tick("alu_after");
    check("alu_we_off", 32'(write_enable), 32'd0);

    // Scoreboard and long-latency path.
    issue_valid = 1'b1; issue_reg = 5'd8; query_reg1 = 5'd8; query_reg2 = 5'd0;
    tick("issue8");
    issue_valid = 1'b0;
    check("busy8_set", 32'(query_busy1), 32'd1);
    mem_valid = 1'b1; mem_reg = 5'd8; mem_data = 32'h12345678;
    tick("xfer8");
    mem_valid = 1'b0;
`ifdef WB_BYPASS_EN
    check("byp_we", 32'(write_enable), 32'd1);
    check("byp_reg", 32'(write_reg), 32'd8);
    check("byp_busy", 32'(query_busy1), 32'd0);
    check("byp_count", 32'(fifo_count), 32'd0);
    tick("lat_idle");
`else
    check("lat_we0", 32'(write_enable), 32'd0);
    check("lat_busy_hold", 32'(query_busy1), 32'd1);
    tick("lat2");
    check("lat_we", 32'(write_enable), 32'd1);
    check("lat_reg", 32'(write_reg), 32'd8);
    check("lat_data", write_data, 32'h12345678);
    check("lat_busy", 32'(query_busy1), 32'd0);
`endif

    // ALU priority fills the FIFO, then drain in order.
    alu_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      alu_reg = 5'(10 + i); alu_data = 32'(i * 3);
      mem_valid = 1'b1; mem_reg = 5'(i); mem_data = 32'hC0DE0000 + 32'(i);
      tick("fill");
    end
    mem_valid = 1'b0;
    check("full_count", 32'(fifo_count), 32'd4);
    check("full_ready", 32'(mem_ready), 32'd0);
    alu_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick("drain");
      check("drain_reg", 32'(write_reg), 32'(i));
      check("drain_ready", 32'(mem_ready), 32'd1);
    end

    // Simultaneous push and pop with two entries resident.
    alu_valid = 1'b1; alu_reg = 5'd20; alu_data = 32'h0;
    for (int i = 0; i < 2; i++) begin
      mem_valid = 1'b1; mem_reg = 5'(21 + i); mem_data = 32'hBEEF0000 + 32'(i);
      tick("pp_fill");
    end
    alu_valid = 1'b0;
    for (int i = 2; i < 6; i++) begin
      mem_reg = 5'(21 + i); mem_data = 32'hBEEF0000 + 32'(i);
      tick("pp");
      check("pp_count", 32'(fifo_count), 32'd2);
      check("pp_reg", 32'(write_reg), 32'(21 + i - 2));
    end
    mem_valid = 1'b0;
    tick("pp_drain0");
    tick("pp_drain1");

    // Register zero.
    mem_valid = 1'b1; mem_reg = 5'd0; mem_data = 32'hFFFFFFFF;
    alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'h77777777;
    issue_valid = 1'b1; issue_reg = 5'd0; query_reg1 = 5'd0; query_reg2 = 5'd0;
    tick("r0");
    check("r0_we", 32'(write_enable), 32'd0);
    check("r0_count", 32'(fifo_count), 32'd0);
    check("r0_busy", 32'(query_busy1), 32'd0);
    idle_inputs();
    tick("r0_after");
    check("r0_we2", 32'(write_enable), 32'd0);

    // Random traffic; an offer not yet accepted is held stable.
    last_xfer = 1'b0;
    for (int n = 0; n < 400; n++) begin
      alu_valid = ($urandom_range(0, 9) < 4);
      alu_reg   = 5'($urandom_range(0, 31));
      alu_data  = $urandom;
      if (!(mem_valid && !last_xfer)) begin
        mem_valid = $urandom_range(0, 1) == 1;
        mem_reg   = 5'($urandom_range(0, 31));
        mem_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_reg   = 5'($urandom_range(0, 31));
      query_reg1  = 5'($urandom_range(0, 31));
      query_reg2  = 5'($urandom_range(0, 31));
      reset       = (n != 200);
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
